// File: rtl/cam_config_seq.sv
// rtl/cam_config_seq.sv - camera configuration sequencer: ROM table walker driving an SCCB master
//
// Walks a registered configuration ROM from entry 0. Each entry {sub, dat} is
// decoded as END (all ones), DELAY (sub all ones, dat units of UNIT_CYCLES) or
// WRITE (issued to the SCCB master over a start/ready handshake). Every wait on
// the master is bounded by TIMEOUT_CYCLES; expiry parks the sequencer in ERROR.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   start          level; a high sample in IDLE/DONE/ERROR launches a run
//   rom_addr       registered ROM address
//   rom_data       ROM entry {sub, dat}, valid one cycle after rom_addr
//   sccb_ready     master idle/ready
//   sccb_start     one-cycle request pulse to the master
//   sccb_sub_addr  sub-address held for the duration of a transfer
//   sccb_data      data held for the duration of a transfer
//   busy/done/error  run status levels
//   write_count    writes completed in the current or last run
module cam_config_seq #(
   parameter int ROM_AW         = 8,
   parameter int SUB_W          = 8,
   parameter int DAT_W          = 8,
   parameter int UNIT_CYCLES    = 25000,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [ROM_AW-1:0]      rom_addr,
   input  logic [SUB_W+DAT_W-1:0] rom_data,
   input  logic                   sccb_ready,
   output logic                   sccb_start,
   output logic [SUB_W-1:0]       sccb_sub_addr,
   output logic [DAT_W-1:0]       sccb_data,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [ROM_AW:0]        write_count
);

   // Counters only ever hold values up to LAST, so size them for that.
   localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WAIT_RDY, S_ISSUE,
      S_WAIT_ACK, S_WAIT_CPL, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t             state_q, state_d;
   logic [ROM_AW-1:0]  ptr_q;
   logic [ROM_AW-1:0]  rom_addr_q;
   logic               sccb_start_q;
   logic [SUB_W-1:0]   sub_q;
   logic [DAT_W-1:0]   dat_q;
   logic               busy_q, done_q, error_q;
   logic [ROM_AW:0]    wcnt_q;
   logic [DAT_W-1:0]   unit_q;
   logic [CYC_W-1:0]   cyc_q;
   logic [TMO_W-1:0]   tmo_q;

   logic [SUB_W-1:0]   rom_sub;
   logic [DAT_W-1:0]   rom_dat;
   logic               is_end, is_delay, launch, waiting, tmo_hit;
   state_t             adv_state;

   assign rom_sub   = rom_data[SUB_W+DAT_W-1:DAT_W];
   assign rom_dat   = rom_data[DAT_W-1:0];
   assign is_end    = &rom_data;
   assign is_delay  = &rom_sub;
   assign launch    = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
   assign waiting   = state_q inside {S_WAIT_RDY, S_WAIT_ACK, S_WAIT_CPL};
   assign tmo_hit   = (tmo_q == TMO_LAST);
   // The last table slot finishes the run instead of wrapping to entry 0.
   assign adv_state = (&ptr_q) ? S_DONE : S_FETCH;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_FETCH;
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            if (is_end)                 state_d = S_DONE;
            else if (is_delay)          state_d = (rom_dat == '0) ? adv_state : S_DELAY;
            else                        state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (sccb_ready)             state_d = S_ISSUE;
            else if (tmo_hit)           state_d = S_ERROR;
         end
         S_ISSUE:    state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!sccb_ready)            state_d = S_WAIT_CPL;
            else if (tmo_hit)           state_d = S_ERROR;
         end
         S_WAIT_CPL: begin
            if (sccb_ready)             state_d = adv_state;
            else if (tmo_hit)           state_d = S_ERROR;
         end
         // Exit on the final cycle of the last unit: dwell is dat * UNIT_CYCLES.
         S_DELAY: if (cyc_q == '0 && unit_q == DAT_W'(1)) state_d = adv_state;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         rom_addr_q   <= '0;
         sccb_start_q <= 1'b0;
         sub_q        <= '0;
         dat_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         wcnt_q       <= '0;
         unit_q       <= '0;
         cyc_q        <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         // Status outputs are registered from the next state so they align with it.
         sccb_start_q <= (state_d == S_ISSUE);
         busy_q       <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
         done_q       <= (state_d == S_DONE);
         error_q      <= (state_d == S_ERROR);
         // Cleared whenever a wait state is entered (including wait-to-wait hops).
         tmo_q        <= (waiting && state_d == state_q) ? tmo_q + 1'b1 : '0;

         if (launch) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            wcnt_q     <= '0;
         end else if (state_d == S_FETCH) begin
            ptr_q      <= ptr_q + 1'b1;
            rom_addr_q <= ptr_q + 1'b1;
         end

         if (state_q == S_WAIT_CPL && sccb_ready) wcnt_q <= wcnt_q + 1'b1;

         if (state_q == S_DECODE && state_d == S_WAIT_RDY) begin
            sub_q <= rom_sub;
            dat_q <= rom_dat;
         end

         if (state_q == S_DECODE && state_d == S_DELAY) begin
            unit_q <= rom_dat;
            cyc_q  <= CYC_LAST;
         end else if (state_q == S_DELAY) begin
            if (cyc_q == '0) begin
               cyc_q  <= CYC_LAST;
               unit_q <= unit_q - 1'b1;
            end else begin
               cyc_q  <= cyc_q - 1'b1;
            end
         end
      end
   end

   assign rom_addr      = rom_addr_q;
   assign sccb_start    = sccb_start_q;
   assign sccb_sub_addr = sub_q;
   assign sccb_data     = dat_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign write_count   = wcnt_q;

endmodule

// File: tb/tb_cam_config_seq.sv
// tb/tb_cam_config_seq.sv - scoreboard bench for cam_config_seq
module tb_cam_config_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        ready_a = 1'b1, ready_b = 1'b1;
   logic        stuck_a = 1'b0;

   logic [7:0]  rom_addr_a;
   logic [15:0] rd_a;
   logic        sccb_start_a, busy_a, done_a, error_a;
   logic [7:0]  sub_a, dat_a;
   logic [8:0]  wcnt_a;

   logic [1:0]  rom_addr_b;
   logic [15:0] rd_b;
   logic        sccb_start_b, busy_b, done_b, error_b;
   logic [7:0]  sub_b, dat_b;
   logic [2:0]  wcnt_b;

   logic [15:0] rom_a [256];
   logic [15:0] rom_b [4];
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cam_config_seq #(.UNIT_CYCLES(10), .TIMEOUT_CYCLES(50)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rd_a),
      .sccb_ready(ready_a), .sccb_start(sccb_start_a), .sccb_sub_addr(sub_a),
      .sccb_data(dat_a), .busy(busy_a), .done(done_a), .error(error_a),
      .write_count(wcnt_a));

   cam_config_seq #(.ROM_AW(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rd_b),
      .sccb_ready(ready_b), .sccb_start(sccb_start_b), .sccb_sub_addr(sub_b),
      .sccb_data(dat_b), .busy(busy_b), .done(done_b), .error(error_b),
      .write_count(wcnt_b));

   // Registered ROMs: data valid one cycle after the address.
   always @(posedge clk) begin
      rd_a <= rom_a[rom_addr_a];
      rd_b <= rom_b[rom_addr_b];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SCCB master models: drop ready one cycle after the pulse, raise it 20 later.
   logic seen_a = 1'b0, seen_b = 1'b0;
   int   hold_a = 0, hold_b = 0;
   always @(negedge clk) begin
      if (stuck_a) ready_a = 1'b0;
      else if (seen_a) begin ready_a = 1'b0; hold_a = 20; end
      else if (hold_a > 0) begin hold_a--; if (hold_a == 0) ready_a = 1'b1; end
      else ready_a = 1'b1;
      seen_a = sccb_start_a;

      if (seen_b) begin ready_b = 1'b0; hold_b = 20; end
      else if (hold_b > 0) begin hold_b--; if (hold_b == 0) ready_b = 1'b1; end
      else ready_b = 1'b1;
      seen_b = sccb_start_b;
   end

   // Monitors: every pulse pops one expected {sub, dat} from its queue.
   logic prev_a = 1'b0, prev_b = 1'b0;
   always @(negedge clk) begin
      if (sccb_start_a) begin
         chk("a_pulse_width", 32'(prev_a), 32'd0);
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_pulse: got %h%h expected none", sub_a, dat_a);
         end else chk("a_pulse_data", 32'({sub_a, dat_a}), 32'(qa.pop_front()));
      end
      prev_a = sccb_start_a;
      if (sccb_start_b) begin
         chk("b_pulse_width", 32'(prev_b), 32'd0);
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_pulse: got %h%h expected none", sub_b, dat_b);
         end else chk("b_pulse_data", 32'({sub_b, dat_b}), 32'(qb.pop_front()));
      end
      prev_b = sccb_start_b;
   end

   task automatic fill_a();
      for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
   endtask

   task automatic pulse_start_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(done_a || error_a) && n < 3000);
      if (n >= 3000) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bcnt;
      logic wrapped, seen_nz;

      for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;
      fill_a();
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
      chk("rst_sccb_start", 32'(sccb_start_a), 32'd0);
      chk("rst_sub_dat", 32'({sub_a, dat_a}), 32'd0);
      chk("rst_status", 32'({busy_a, done_a, error_a}), 32'd0);
      chk("rst_wcount", 32'(wcnt_a), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Two writes then END; also the start-to-pulse latency.
      rom_a[0] = 16'h1280; rom_a[1] = 16'h40D0; rom_a[2] = 16'hFFFF;
      qa.push_back(16'h1280); qa.push_back(16'h40D0);
      start_a = 1'b1;
      n = 0;
      do begin @(negedge clk); start_a = 1'b0; n++; end while (!sccb_start_a && n < 20);
      chk("t1_latency", 32'(n), 32'd4);
      wait_done_a("t1");
      chk("t1_done", 32'(done_a), 32'd1);
      chk("t1_error", 32'(error_a), 32'd0);
      chk("t1_busy", 32'(busy_a), 32'd0);
      chk("t1_wcount", 32'(wcnt_a), 32'd2);
      chk("t1_queue", 32'(qa.size()), 32'd0);

      // In-table delay of 3 units of 10 cycles.
      rom_a[0] = 16'h1280; rom_a[1] = 16'hFF03; rom_a[2] = 16'h40D0; rom_a[3] = 16'hFFFF;
      qa.push_back(16'h1280); qa.push_back(16'h40D0);
      pulse_start_a();
      n = 0;
      while (rom_addr_a != 8'd1 && n < 500) begin @(negedge clk); n++; end
      n = 0;
      do begin @(negedge clk); n++; end while (rom_addr_a != 8'd2 && n < 200);
      // FETCH(1) + DECODE(1) + 30 delay cycles between the two address changes.
      chk("t2_fetch_to_fetch", 32'(n), 32'd32);
      wait_done_a("t2");
      chk("t2_done", 32'(done_a), 32'd1);
      chk("t2_wcount", 32'(wcnt_a), 32'd2);
      chk("t2_queue", 32'(qa.size()), 32'd0);

      // Master stuck not-ready: timeout in WAIT_RDY, then a clean retry.
      fill_a();
      rom_a[0] = 16'h1280;
      @(negedge clk) stuck_a = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk) start_a = 1'b1;
      bcnt = 0; n = 0;
      do begin
         @(negedge clk); start_a = 1'b0; n++;
         if (busy_a) bcnt++;
      end while (!error_a && n < 200);
      // FETCH + DECODE + 50 cycles in WAIT_RDY.
      chk("t3_busy_cycles", 32'(bcnt), 32'd52);
      chk("t3_error", 32'(error_a), 32'd1);
      chk("t3_done", 32'(done_a), 32'd0);
      chk("t3_wcount", 32'(wcnt_a), 32'd0);
      stuck_a = 1'b0;
      repeat (3) @(negedge clk);
      qa.push_back(16'h1280);
      pulse_start_a();
      chk("t3_error_cleared", 32'(error_a), 32'd0);
      wait_done_a("t3r");
      chk("t3r_done", 32'(done_a), 32'd1);
      chk("t3r_wcount", 32'(wcnt_a), 32'd1);

      // Four-entry table with no END: finishes at the last slot, no wrap.
      rom_b[0] = 16'h1101; rom_b[1] = 16'h2202; rom_b[2] = 16'h3303; rom_b[3] = 16'h4404;
      for (int i = 0; i < 4; i++) qb.push_back(rom_b[i]);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      wrapped = 1'b0; seen_nz = 1'b0; n = 0;
      do begin
         @(negedge clk); n++;
         if (rom_addr_b != 2'd0) seen_nz = 1'b1;
         else if (seen_nz) wrapped = 1'b1;
      end while (!done_b && n < 3000);
      chk("t4_nowrap", 32'(wrapped), 32'd0);
      chk("t4_done", 32'(done_b), 32'd1);
      chk("t4_wcount", 32'(wcnt_b), 32'd4);
      chk("t4_rom_addr", 32'(rom_addr_b), 32'd3);
      chk("t4_queue", 32'(qb.size()), 32'd0);

      // Reset during WAIT_CPL of the second write, then replay.
      fill_a();
      rom_a[0] = 16'h1280; rom_a[1] = 16'h40D0;
      qa.push_back(16'h1280); qa.push_back(16'h40D0);
      pulse_start_a();
      n = 0;
      while (!(sccb_start_a && wcnt_a == 9'd1) && n < 500) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      chk("t5_rom_addr", 32'(rom_addr_a), 32'd0);
      chk("t5_sccb_start", 32'(sccb_start_a), 32'd0);
      chk("t5_status", 32'({busy_a, done_a, error_a}), 32'd0);
      chk("t5_wcount", 32'(wcnt_a), 32'd0);
      chk("t5_sub_dat", 32'({sub_a, dat_a}), 32'd0);
      repeat (30) @(negedge clk);
      qa.push_back(16'h1280); qa.push_back(16'h40D0);
      pulse_start_a();
      wait_done_a("t5r");
      chk("t5r_wcount", 32'(wcnt_a), 32'd2);
      chk("t5r_queue", 32'(qa.size()), 32'd0);

      // start held high: no mid-run restart, immediate relaunch after done.
      for (int k = 0; k < 2; k++) begin qa.push_back(16'h1280); qa.push_back(16'h40D0); end
      @(negedge clk) start_a = 1'b1;
      wait_done_a("t6");
      chk("t6_first_wcount", 32'(wcnt_a), 32'd2);
      @(negedge clk);
      chk("t6_relaunch_addr", 32'(rom_addr_a), 32'd0);
      chk("t6_relaunch_busy", 32'(busy_a), 32'd1);
      start_a = 1'b0;
      wait_done_a("t6b");
      chk("t6b_done", 32'(done_a), 32'd1);
      chk("t6b_wcount", 32'(wcnt_a), 32'd2);
      repeat (3) @(negedge clk);
      chk("t6_queue", 32'(qa.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
